// File: rtl/imem_loader_if.sv
// Byte-stream input and imem/CPU-control outputs of the instruction-memory loader.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready are both high.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program into imem, holding the CPU in reset
// until every word has been written.
module imem_loader #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {
        S_HDR0, S_HDR1, S_CHK, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_d;
    logic [15:0] n_q;
    logic [15:0] idx_q;
    logic [1:0]  bcnt_q;
    logic [23:0] asm_q;
    logic        accept;
    logic        last_word;

    assign bus.in_ready = !rst && (state == S_HDR0 || state == S_HDR1 || state == S_DATA);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_word    = (idx_q == n_q - 16'd1);
    assign dbg_state    = state;

    always_comb begin
        state_d = state;
        case (state)
            S_HDR0:  if (accept) state_d = S_HDR1;
            S_HDR1:  if (accept) state_d = S_CHK;
            S_CHK: begin
                if (n_q == 16'd0)               state_d = S_DONE;
                else if ({1'b0, n_q} > DEPTH_L) state_d = S_ERR;
                else                            state_d = S_DATA;
            end
            S_DATA:  if (accept && bcnt_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_DONE : S_DATA;
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_HDR0;
            n_q            <= '0;
            idx_q          <= '0;
            bcnt_q         <= '0;
            asm_q          <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= ADDR_W'(BASE_ADDR);
            bus.imem_wdata <= '0;
            bus.cpu_rst    <= 1'b1;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            state       <= state_d;
            bus.imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_HDR0: n_q[7:0]  <= bus.in_data;
                    S_HDR1: n_q[15:8] <= bus.in_data;
                    S_DATA: begin
                        bcnt_q <= bcnt_q + 2'd1;
                        case (bcnt_q)
                            2'd0: asm_q[7:0]   <= bus.in_data;
                            2'd1: asm_q[15:8]  <= bus.in_data;
                            2'd2: asm_q[23:16] <= bus.in_data;
                            default: begin
                                // Final byte goes straight into the write data so the
                                // strobe lands in the cycle right after this handshake.
                                bus.imem_we    <= 1'b1;
                                bus.imem_waddr <= ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];
                                bus.imem_wdata <= {bus.in_data, asm_q};
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE && !last_word) idx_q <= idx_q + 16'd1;
            // Status flags track the state being entered, so they change on the same edge.
            bus.done    <= (state_d == S_DONE);
            bus.error   <= (state_d == S_ERR);
            bus.cpu_rst <= (state_d != S_DONE);
        end
    end
endmodule
